// File: rtl/med_pkg.sv
// Shared definitions for the medication scheduler: command opcodes, log kinds
// and the log entry width helper.
package med_pkg;

  localparam logic [1:0] OP_ADD     = 2'd0;
  localparam logic [1:0] OP_ACK     = 2'd1;
  localparam logic [1:0] OP_DEL     = 2'd2;
  localparam logic [1:0] OP_CLR_OVF = 2'd3;

  localparam logic LOG_DUE = 1'b0;
  localparam logic LOG_ACK = 1'b1;

  // Log entry layout is {kind, slot, time}.
  function automatic int unsigned log_entry_w(input int unsigned slot_w,
                                              input int unsigned time_w);
    return 1 + slot_w + time_w;
  endfunction

endpackage

// File: rtl/med_log_fifo.sv
// Show-ahead synchronous FIFO with a registered head, push-side full flag
// and valid/ready pop. A push while full is accepted only alongside a pop.
module med_log_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full_c,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nx;
  logic [CW-1:0]    count_nx, count_left;
  logic [WIDTH-1:0] head_nx;
  logic             pop_c, push_ok;

  // Next head: bypass the incoming word when it lands in an otherwise empty FIFO.
  always_comb begin
    full_c     = (count == CW'(DEPTH));
    pop_c      = valid & ready;
    push_ok    = push & (~full_c | pop_c);
    count_nx   = count + CW'(push_ok) - CW'(pop_c);
    count_left = count - CW'(pop_c);
    rd_nx      = rd_ptr + AW'(pop_c);
    head_nx    = mem[rd_nx];
    if (count_left == '0) head_nx = push_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      data   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nx;
      count  <= count_nx;
      valid  <= (count_nx != '0);
      data   <= head_nx;
    end
  end

endmodule

// File: rtl/med_sched_multi.sv
// Multi-slot medication scheduler: prescaled time base, slot table with
// match/due/pending tracking, ack handling and a log FIFO of due/ack events.
module med_sched_multi
  import med_pkg::*;
#(
  parameter  int unsigned SLOTS     = 16,
  parameter  int unsigned TIME_W    = 8,
  parameter  int unsigned PRESCALE  = 1,
  parameter  int unsigned LOG_DEPTH = 16,
  localparam int unsigned SLOT_W    = $clog2(SLOTS),
  localparam int unsigned LOG_W     = log_entry_w(SLOT_W, TIME_W),
  localparam int unsigned CNT_W     = $clog2(LOG_DEPTH) + 1,
  localparam int unsigned PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [SLOT_W-1:0] cmd_slot,
  input  logic [TIME_W-1:0] cmd_time,
  output logic [TIME_W-1:0] now,
  output logic [SLOTS-1:0]  due,
  output logic              alarm,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [LOG_W-1:0]  log_data,
  output logic [CNT_W-1:0]  log_count,
  output logic              log_overflow
);

  logic [PRE_W-1:0]  presc_q, presc_nx;
  logic [TIME_W-1:0] now_nx;
  logic              tick_c;

  logic [TIME_W-1:0] slot_time_q [SLOTS];
  logic [TIME_W-1:0] slot_time_nx [SLOTS];
  logic [SLOTS-1:0]  valid_q, valid_nx, due_nx, pend_q, pend_nx;

  logic              cmd_act_c, cmd_en_c, ack_c, pend_any_c;
  logic [SLOT_W-1:0] pend_idx_c;
  logic              push_c, full_c, drop_c, ovf_nx;
  logic [LOG_W-1:0]  push_data_c;

  // Time base
  always_comb begin
    tick_c   = ena && (presc_q == PRE_W'(PRESCALE - 1));
    presc_nx = presc_q;
    now_nx   = now;
    if (ena) presc_nx = tick_c ? '0 : presc_q + PRE_W'(1);
    if (tick_c) now_nx = now + TIME_W'(1);
  end

  // Command decode and pending arbiter (lowest index wins)
  always_comb begin
    cmd_act_c  = cmd_valid & ena;
    cmd_en_c   = cmd_act_c & ((SLOT_W+1)'(cmd_slot) < (SLOT_W+1)'(SLOTS));
    ack_c      = cmd_en_c && (cmd_op == OP_ACK) && due[cmd_slot];
    pend_any_c = 1'b0;
    pend_idx_c = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        pend_any_c = 1'b1;
        pend_idx_c = SLOT_W'(i);
      end
    end
  end

  // Slot update: command first, then arbiter clear, then match on the new time
  always_comb begin
    slot_time_nx = slot_time_q;
    valid_nx     = valid_q;
    due_nx       = due;
    pend_nx      = pend_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (cmd_en_c && (cmd_slot == SLOT_W'(i))) begin
        case (cmd_op)
          OP_ADD: begin
            slot_time_nx[i] = cmd_time;
            valid_nx[i]     = 1'b1;
            due_nx[i]       = 1'b0;
            pend_nx[i]      = 1'b0;
          end
          OP_ACK: due_nx[i] = 1'b0;
          OP_DEL: begin
            valid_nx[i] = 1'b0;
            due_nx[i]   = 1'b0;
            pend_nx[i]  = 1'b0;
          end
          default: ;
        endcase
      end
      if (pend_any_c && !ack_c && (pend_idx_c == SLOT_W'(i))) pend_nx[i] = 1'b0;
      if (tick_c && valid_nx[i] && (slot_time_nx[i] == now_nx)) begin
        due_nx[i]  = 1'b1;
        pend_nx[i] = 1'b1;
      end
    end
  end

  // Log source selection and overflow tracking
  always_comb begin
    push_c      = ack_c | pend_any_c;
    push_data_c = ack_c ? {LOG_ACK, cmd_slot, now}
                        : {LOG_DUE, pend_idx_c, slot_time_q[pend_idx_c]};
    drop_c      = push_c & full_c & ~(log_valid & log_ready);
    ovf_nx      = log_overflow;
    if (cmd_act_c && (cmd_op == OP_CLR_OVF)) ovf_nx = 1'b0;
    if (drop_c) ovf_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      now          <= '0;
      valid_q      <= '0;
      due          <= '0;
      pend_q       <= '0;
      alarm        <= 1'b0;
      log_overflow <= 1'b0;
      for (int i = 0; i < SLOTS; i++) slot_time_q[i] <= '0;
    end else begin
      presc_q      <= presc_nx;
      now          <= now_nx;
      valid_q      <= valid_nx;
      due          <= due_nx;
      pend_q       <= pend_nx;
      alarm        <= |due_nx;
      log_overflow <= ovf_nx;
      slot_time_q  <= slot_time_nx;
    end
  end

  med_log_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_data_c),
    .full_c    (full_c),
    .valid     (log_valid),
    .ready     (log_ready),
    .data      (log_data),
    .count     (log_count)
  );

endmodule

// File: tb/tb_med_sched_multi.sv
// Directed bench for med_sched_multi: one PRESCALE=1 and one PRESCALE=4
// instance share stimulus; expectations are hand-computed.
module tb_med_sched_multi;
  import med_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_slot = 4'd0;
  logic [7:0] cmd_time = 8'd0;
  logic       log_ready = 1'b0;

  logic [7:0]  now1, now4;
  logic [15:0] due1, due4;
  logic        alarm1, alarm4, lv1, lv4, ovf1, ovf4;
  logic [12:0] ld1, ld4;
  logic [4:0]  lc1, lc4;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_now = 8'd0;
  logic [7:0] t_ack;
  logic [3:0] s3 [3];
  logic [12:0] exp_e;
  int         guard;

  always #5 clk = ~clk;

  med_sched_multi #(.SLOTS(16), .TIME_W(8), .PRESCALE(1), .LOG_DEPTH(16)) u_p1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_slot(cmd_slot), .cmd_time(cmd_time), .now(now1), .due(due1), .alarm(alarm1),
    .log_valid(lv1), .log_ready(log_ready), .log_data(ld1), .log_count(lc1),
    .log_overflow(ovf1));

  med_sched_multi #(.SLOTS(16), .TIME_W(8), .PRESCALE(4), .LOG_DEPTH(16)) u_p4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_slot(cmd_slot), .cmd_time(cmd_time), .now(now4), .due(due4), .alarm(alarm4),
    .log_valid(lv4), .log_ready(log_ready), .log_data(ld4), .log_count(lc4),
    .log_overflow(ovf4));

  function automatic logic [12:0] ent(input logic k, input logic [3:0] s, input logic [7:0] t);
    return {k, s, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n && ena) exp_now = exp_now + 8'd1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] slot, input logic [7:0] t);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_slot  = slot;
    cmd_time  = t;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    ena       = 1'b0;
    log_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_now = 8'd0;
  endtask

  // Load every slot with time 20 and let all 16 due entries fill the log.
  task automatic fill_full();
    for (int i = 0; i < 16; i++) cmd(OP_ADD, 4'(i), 8'd20);
    repeat (4) step();
    chk("fill_due_all", 32'(due1), 32'h0000_ffff);
    repeat (16) step();
    chk("fill_count", 32'(lc1), 32'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    s3[0] = 4'd1; s3[1] = 4'd4; s3[2] = 4'd9;

    // Reset state
    #2;
    chk("rst_now", 32'(now1), 32'd0);
    chk("rst_due", 32'(due1), 32'd0);
    chk("rst_alarm", 32'(alarm1), 32'd0);
    chk("rst_log_valid", 32'(lv1), 32'd0);
    chk("rst_log_count", 32'(lc1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    #10;
    rst_n   = 1'b1;
    exp_now = 8'd0;
    ena     = 1'b1;

    // Single slot due at time 5
    cmd(OP_ADD, 4'd3, 8'd5);
    repeat (4) step();
    chk("p1_now5", 32'(now1), 32'(exp_now));
    chk("p1_due3", 32'(due1), 32'h0000_0008);
    chk("p1_alarm", 32'(alarm1), 32'd1);
    chk("p1_no_log_yet", 32'(lv1), 32'd0);
    step();
    chk("p1_log_valid", 32'(lv1), 32'd1);
    chk("p1_log_data", 32'(ld1), 32'(ent(LOG_DUE, 4'd3, 8'd5)));
    chk("p1_log_count", 32'(lc1), 32'd1);
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    chk("p1_pop_empty", 32'(lv1), 32'd0);
    chk("p1_pop_count", 32'(lc1), 32'd0);

    // Three simultaneous matches log in index order
    do_reset();
    ena = 1'b1;
    cmd(OP_ADD, 4'd1, 8'd7);
    cmd(OP_ADD, 4'd4, 8'd7);
    cmd(OP_ADD, 4'd9, 8'd7);
    repeat (4) step();
    chk("p2_due", 32'(due1), 32'h0000_0212);
    repeat (3) step();
    chk("p2_count", 32'(lc1), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("p2_entry", 32'(ld1), 32'(ent(LOG_DUE, s3[k], 8'd7)));
      log_ready = 1'b1;
      step();
      log_ready = 1'b0;
    end
    chk("p2_drained", 32'(lc1), 32'd0);

    // ACK logs {1,slot,now}; a repeated ACK is a no-op
    do_reset();
    ena = 1'b1;
    cmd(OP_ADD, 4'd3, 8'd10);
    repeat (9) step();
    chk("p3_due3", 32'(due1), 32'h0000_0008);
    step();
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    chk("p3_now12", 32'(now1), 32'd12);
    chk("p3_empty", 32'(lv1), 32'd0);
    cmd(OP_ACK, 4'd3, 8'd0);
    chk("p3_due_clr", 32'(due1), 32'd0);
    chk("p3_alarm_clr", 32'(alarm1), 32'd0);
    chk("p3_ack_valid", 32'(lv1), 32'd1);
    chk("p3_ack_entry", 32'(ld1), 32'(ent(LOG_ACK, 4'd3, 8'd12)));
    cmd(OP_ACK, 4'd3, 8'd0);
    chk("p3_second_ack", 32'(lc1), 32'd1);
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;

    // Overflow, clear, and push+pop while full
    do_reset();
    ena = 1'b1;
    fill_full();
    chk("p4_no_ovf", 32'(ovf1), 32'd0);
    cmd(OP_ACK, 4'd0, 8'd0);
    chk("p4_ovf_set", 32'(ovf1), 32'd1);
    chk("p4_count_full", 32'(lc1), 32'd16);
    chk("p4_due0_clr", 32'(due1[0]), 32'd0);
    cmd(OP_ACK, 4'd1, 8'd0);
    cmd(OP_CLR_OVF, 4'd0, 8'd0);
    chk("p4_ovf_clr", 32'(ovf1), 32'd0);
    t_ack     = exp_now;
    log_ready = 1'b1;
    cmd(OP_ACK, 4'd2, 8'd0);
    log_ready = 1'b0;
    chk("p4_pushpop_count", 32'(lc1), 32'd16);
    chk("p4_pushpop_ovf", 32'(ovf1), 32'd0);
    for (int k = 0; k < 16; k++) begin
      exp_e = (k < 15) ? ent(LOG_DUE, 4'(k + 1), 8'd20) : ent(LOG_ACK, 4'd2, t_ack);
      chk("p4_entry", 32'(ld1), 32'(exp_e));
      log_ready = 1'b1;
      step();
      log_ready = 1'b0;
    end
    chk("p4_drained", 32'(lc1), 32'd0);

    // Prescale 4 with ena gaps, wrap and a match at time 0
    do_reset();
    ena = 1'b1;
    cmd(OP_ADD, 4'd0, 8'd0);
    repeat (2) step();
    chk("p5_now_hold", 32'(now4), 32'd0);
    step();
    chk("p5_now1", 32'(now4), 32'd1);
    ena = 1'b0;
    repeat (3) step();
    chk("p5_frozen", 32'(now4), 32'd1);
    ena = 1'b1;
    repeat (3) step();
    chk("p5_partial", 32'(now4), 32'd1);
    step();
    chk("p5_now2", 32'(now4), 32'd2);
    guard = 0;
    while (now4 != 8'd255 && guard < 1100) begin
      step();
      guard++;
    end
    chk("p5_reach255", 32'(now4), 32'd255);
    chk("p5_no_early_due", 32'(due4), 32'd0);
    repeat (3) step();
    chk("p5_hold255", 32'(now4), 32'd255);
    step();
    chk("p5_wrap0", 32'(now4), 32'd0);
    chk("p5_due0", 32'(due4), 32'h0000_0001);
    chk("p5_alarm", 32'(alarm4), 32'd1);

    // Asynchronous reset mid-drain
    do_reset();
    ena = 1'b1;
    fill_full();
    cmd(OP_ACK, 4'd0, 8'd0);
    chk("p6_ovf_pre", 32'(ovf1), 32'd1);
    log_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("p6_now", 32'(now1), 32'd0);
    chk("p6_due", 32'(due1), 32'd0);
    chk("p6_alarm", 32'(alarm1), 32'd0);
    chk("p6_valid", 32'(lv1), 32'd0);
    chk("p6_count", 32'(lc1), 32'd0);
    chk("p6_ovf", 32'(ovf1), 32'd0);
    log_ready = 1'b0;
    rst_n     = 1'b1;
    exp_now   = 8'd0;
    repeat (3) step();
    chk("p6_post_now", 32'(now1), 32'(exp_now));
    chk("p6_post_due", 32'(due1), 32'd0);
    chk("p6_post_valid", 32'(lv1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
